// File: rtl/fa16_rev_driver.sv
// Single-rail to dual-rail front end and result collector for the 16-bit reversible adder.
// Drives an evaluate code for SETTLE_CYCLES, captures and rail-checks the result, then spaces with null.
module fa16_rev_driver #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NULL_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // operand handshake
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_cin,
  // dual-rail drive to the adder
  output logic [15:0] a,
  output logic [15:0] a_not,
  output logic [15:0] b,
  output logic [15:0] b_not,
  output logic        c0_f,
  output logic        c0_f_not,
  // dual-rail returns from the adder
  input  logic [15:0] s,
  input  logic [15:0] s_not,
  input  logic [15:0] a_b,
  input  logic [15:0] a_not_b,
  input  logic        c15,
  input  logic        c15_not,
  input  logic        c0_b,
  input  logic        c0_not_b,
  input  logic        z,
  input  logic        z_not,
  // result handshake
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_cout,
  output logic        out_zero,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_SPACER,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] a_not;
    logic [15:0] b;
    logic [15:0] b_not;
    logic        c0_f;
    logic        c0_f_not;
  } rails_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        zero;
    logic        err;
  } result_t;

  // The counter runs from (window-1) down to 0, so it only needs to hold the larger window minus one.
  localparam int CNT_MAX = (SETTLE_CYCLES > NULL_CYCLES) ? SETTLE_CYCLES : NULL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] NULL_LOAD   = CNT_W'(NULL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  rails_t           rails_q, rails_d;
  result_t          res_q,   res_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             rail_err;

  // Bit 0 of the backward A copy is excluded: the macro ties its internal a0 to constant 0.
  assign rail_err = ((s ^ s_not) != 16'hFFFF)
                 || (c15 == c15_not)
                 || (z == z_not)
                 || ((a_b ^ a_not_b) != 16'hFFFF)
                 || (a_b[15:1] != rails_q.a[15:1])
                 || (c0_b != rails_q.c0_f)
                 || (c0_b == c0_not_b);

  // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rails_d   = rails_q;
    res_d     = res_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rails_d = '{a: in_a, a_not: ~in_a, b: in_b, b_not: ~in_b,
                      c0_f: in_cin, c0_f_not: ~in_cin};
          cnt_d   = SETTLE_LOAD;
          state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        if (cnt_q == '0) begin
          res_d = '{sum: s, cout: c15, zero: z, err: rail_err};
          if (rail_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          rails_d = '0;
          cnt_d   = NULL_LOAD;
          state_d = ST_SPACER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SPACER: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rails_q   <= '0;
      res_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rails_q   <= rails_d;
      res_q     <= res_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign a        = rails_q.a;
  assign a_not    = rails_q.a_not;
  assign b        = rails_q.b;
  assign b_not    = rails_q.b_not;
  assign c0_f     = rails_q.c0_f;
  assign c0_f_not = rails_q.c0_f_not;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_RESP);
  assign out_sum   = res_q.sum;
  assign out_cout  = res_q.cout;
  assign out_zero  = res_q.zero;
  assign out_err   = res_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/fa16_rev_driver.md
Name: fa16_rev_driver

Overview:
- Single-rail to dual-rail front end and result collector for the 16-bit reversible adder macro.
- Accepts operands over a valid/ready handshake and drives them onto the adder's dual-rail inputs (a/a_not, b/b_not, c0_f/c0_f_not) for a fixed settle window.
- Captures and rail-checks the dual-rail outputs (s, c15, z and the backward copies a_b, c0_b), then returns all rails to the null spacer.
- Presents the result over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 4, cycles the evaluate code is held on the adder inputs before capture (>=1)
NULL_CYCLES, 2, cycles of all-zero spacer driven after capture before the result is offered (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  operand accept; high only in IDLE
in_a  input  16  operand A
in_b  input  16  operand B
in_cin  input  1  carry-in
a, a_not  output  16 each  dual-rail A to adder
b, b_not  output  16 each  dual-rail B to adder
c0_f, c0_f_not  output  1 each  dual-rail carry-in to adder
s, s_not  input  16 each  dual-rail sum from adder
a_b, a_not_b  input  16 each  dual-rail backward copy of A
c15, c15_not  input  1 each  dual-rail carry-out
c0_b, c0_not_b  input  1 each  dual-rail backward copy of carry-in
z, z_not  input  1 each  dual-rail zero flag
out_valid  output  1  result valid
out_ready  input  1  result accept
out_sum  output  16  captured s
out_cout  output  1  captured c15
out_zero  output  1  captured z
out_err  output  1  rail/consistency error for this result
err_cnt  output  8  saturating count of results with out_err=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE. All dual-rail outputs are 0 (null spacer).
  - out_valid=0; out_sum, out_cout, out_zero and out_err are 0; err_cnt=0.
  - in_ready=1 once rst_n deasserts.
- All rail outputs come directly from flops; there is no combinational path from in_* to the rails.
- FSM states:
  - IDLE: rails null; in_ready=1. On in_valid&&in_ready at edge T:
    - a<=in_a, a_not<=~in_a, b<=in_b, b_not<=~in_b, c0_f<=in_cin, c0_f_not<=~in_cin.
    - Load the settle counter; go to EVAL.
  - EVAL: rails held for exactly SETTLE_CYCLES cycles.
    - At the edge that leaves EVAL, register s, c15, z into out_sum/out_cout/out_zero and compute err.
    - All rails go to 0 on that same edge; go to SPACER.
  - SPACER: rails null for exactly NULL_CYCLES cycles, then go to RESP.
  - RESP: out_valid=1, with outputs stable until out_valid&&out_ready. Then out_valid=0 and return to IDLE on the next edge.
- Latency:
  - out_valid first rises SETTLE_CYCLES+NULL_CYCLES edges after the input handshake edge (6 at defaults).
  - Minimum initiation interval is SETTLE_CYCLES+NULL_CYCLES+2 cycles.
- err=1 if any of the following holds at capture:
  - (s ^ s_not) != 16'hFFFF
  - c15 == c15_not
  - z == z_not
  - (a_b ^ a_not_b) != 16'hFFFF
  - a_b[15:1] != driven a[15:1] (bit 0 is excluded: the macro ties its internal a0 to constant 0)
  - c0_b != driven c0_f
  - c0_b == c0_not_b
- err_cnt increments by 1 when a result with err=1 is captured and saturates at 255. It is cleared only by reset.
- in_valid outside IDLE is ignored; in_ready=0 in EVAL, SPACER and RESP.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation (any state): rails go null immediately, any pending result is discarded, err_cnt=0.

Test Plan:
1. Reset, then in_a=16'h0003, in_b=16'h0005, cin=0 with a bench adder model returning s=16'h0008, c15=0, z=0 with correct complements and backward copies.
   -> During EVAL, a=0003, a_not=FFFC, b=0005, b_not=FFFA, c0_f=0, c0_f_not=1 for exactly 4 cycles. Then all rails 0 for 2 cycles. out_valid rises 6 edges after the handshake with out_sum=0008, out_err=0.
2. in_a=16'hFFFF, in_b=16'h0001, cin=0, model s=0000, c15=1, z=1.
   -> out_sum=0000, out_cout=1, out_zero=1, out_err=0, err_cnt=0.
3. Same as scenario 1 but the model forces s_not[4]=s[4].
   -> out_err=1, err_cnt=1. A following clean transaction gives out_err=0, err_cnt=1.
4. Hold out_ready=0 for 10 cycles in RESP while in_valid=1.
   -> out_valid and outputs stable, in_ready=0, rails null. Asserting out_ready completes the transfer; in_ready=1 on the next cycle.
5. Assert rst_n=0 during the 2nd EVAL cycle.
   -> Rails become 0 without waiting for a clock edge; out_valid stays 0; after release in_ready=1 and no stale result appears.
6. Issue 260 transactions each with a corrupted z rail.
   -> err_cnt saturates at 255; every result has out_err=1.
